bcd_conv_arbiter: RTL and testbench

- Shares one sequential shift-add-3 (double-dabble) binary-to-BCD engine between two requesters, e.g. the register-file display path and the ALU-result display path.
- Round-robin arbitration with a level-request / single-pulse-ack handshake.
- Converts one bit per clock, so the processor's display logic needs no wide combinational converter.
- Results drive the hundreds/tens/units 7-segment decoders and the sign LED.

---
 rtl/bcd_conv_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_arbiter.sv
// ---------------------------------------------------------------------------
// bcd_conv_arbiter
//
// Shares one sequential shift-add-3 (double-dabble) binary-to-BCD engine
// between two requesters using round-robin arbitration. A requester holds a
// level request until it sees a one-cycle ack; the engine then converts one
// operand bit per clock, MSB first, and publishes three BCD digits plus a
// sign flag for the 7-segment decoders and sign LED.
//
// Optional feature (compile-time macro BCD_SIGNED_EN):
//   defined   : operands are two's complement; the magnitude is converted and
//               'negative' reports the sign.
//   undefined : operands are unsigned; 'negative' is always 0.
//
// Parameters:
//   WIDTH     operand width in bits, 4..9 (three BCD digits cover up to 511)
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high reset
//   req0/in0  requester 0 level request and operand
//   req1/in1  requester 1 level request and operand
//   ack0/ack1 one-cycle pulse when that requester's result is valid
//   busy      high from the cycle after grant through the result cycle
//   valid     one-cycle pulse coincident with ack0/ack1
//   owner     requester index of the most recent result (held)
//   centena   hundreds BCD digit (held)
//   dezena    tens BCD digit (held)
//   unidade   units BCD digit (held)
//   negative  sign of the most recent result (held)
// ---------------------------------------------------------------------------
module bcd_conv_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] in0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             valid,
  output logic             owner,
  output logic [3:0]       centena,
  output logic [3:0]       dezena,
  output logic [3:0]       unidade,
  output logic             negative
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [11:0]      work_q;
  logic [WIDTH-1:0] op_q;
  logic             sign_q;
  logic             gid_q;
  logic             last_grant_q;

  logic             grant;
  logic             grant_id;
  logic [WIDTH-1:0] sel_in;
  logic [WIDTH-1:0] mag;
  logic             sgn;
  logic [11:0]      work_adj;
  logic [11:0]      work_shift;
  logic [WIDTH-1:0] op_shift;

  // Next-state, arbitration and handshake outputs.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    grant_id = 1'b0;
    busy     = (state_q != IDLE);
    valid    = (state_q == DONE);
    ack0     = (state_q == DONE) && !gid_q;
    ack1     = (state_q == DONE) &&  gid_q;

    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          // Tie goes to whoever was not served last.
          grant    = 1'b1;
          grant_id = ~last_grant_q;
        end else if (req0) begin
          grant    = 1'b1;
          grant_id = 1'b0;
        end else if (req1) begin
          grant    = 1'b1;
          grant_id = 1'b1;
        end
        if (grant) state_d = SHIFT;
      end
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitude and sign of the requester being granted.
  always_comb begin
    sel_in = grant_id ? in1 : in0;
`ifdef BCD_SIGNED_EN
    sgn = sel_in[WIDTH-1];
    // Two's-complement negate in WIDTH bits; the most-negative value maps to
    // 2^(WIDTH-1), which the unsigned shift path converts correctly.
    mag = sgn ? (~sel_in + WIDTH'(1)) : sel_in;
`else
    sgn = 1'b0;
    mag = sel_in;
`endif
  end

  // One double-dabble step: add 3 to each digit >= 5, then shift the
  // operand's MSB into the BCD register.
  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < 3; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
    {work_shift, op_shift} = {work_adj, op_q} << 1;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      work_q       <= '0;
      op_q         <= '0;
      sign_q       <= 1'b0;
      gid_q        <= 1'b0;
      last_grant_q <= 1'b1;
      owner        <= 1'b0;
      negative     <= 1'b0;
      centena      <= 4'd0;
      dezena       <= 4'd0;
      unidade      <= 4'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant) begin
            op_q   <= mag;
            sign_q <= sgn;
            gid_q  <= grant_id;
            work_q <= '0;
            cnt_q  <= CW'(WIDTH - 1);
          end
        end
        SHIFT: begin
          work_q <= work_shift;
          op_q   <= op_shift;
          if (cnt_q == '0) begin
            // Results are loaded on the edge entering DONE so the digits are
            // already stable during the valid/ack cycle.
            centena      <= work_shift[11:8];
            dezena       <= work_shift[7:4];
            unidade      <= work_shift[3:0];
            negative     <= sign_q;
            owner        <= gid_q;
            last_grant_q <= gid_q;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bcd_conv_arbiter
//
// Self-checking bench for bcd_conv_arbiter (WIDTH=8). Directed scenarios plus
// randomized transactions; expected digits come from plain decimal arithmetic
// on the operand value and the grant order from a round-robin model.
// Works for both the default build and BCD_SIGNED_EN.
// ---------------------------------------------------------------------------
module tb_bcd_conv_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [W-1:0] in0, in1;
  logic         ack0, ack1, busy, valid, owner, negative;
  logic [3:0]   centena, dezena, unidade;

  int checks = 0;
  int errors = 0;
  bit last_m = 1'b1;

  bcd_conv_arbiter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .in0      (in0),
    .req1     (req1),
    .in1      (in1),
    .ack0     (ack0),
    .ack1     (ack1),
    .busy     (busy),
    .valid    (valid),
    .owner    (owner),
    .centena  (centena),
    .dezena   (dezena),
    .unidade  (unidade),
    .negative (negative)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: value interpretation straight from the operand rules.
  function automatic bit model_neg(input logic [W-1:0] v);
`ifdef BCD_SIGNED_EN
    return v[W-1];
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_mag(input logic [W-1:0] v);
    if (model_neg(v)) return (1 << W) - int'(v);
    return int'(v);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    in0   = '0;
    in1   = '0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    last_m = 1'b1;
  endtask

  // Waits for the next result, which must belong to requester 'id' and
  // represent operand 'v'. Optionally drops the request or changes the
  // operand at a given cycle of the wait (0 = never).
  task automatic expect_result(input string tag, input bit id, input logic [W-1:0] v,
                               input int drop_at, input int chg_at, input logic [W-1:0] chg_val);
    int cyc  = 0;
    int bcyc = 0;
    bit seen = 1'b0;
    int mag;
    while (!seen && cyc < 4*W + 8) begin
      @(negedge clk);
      cyc++;
      if (busy) bcyc++;
      if (valid) seen = 1'b1;
      else begin
        if (cyc == drop_at) begin
          if (id) req1 = 1'b0; else req0 = 1'b0;
        end
        if (cyc == chg_at) begin
          if (id) in1 = chg_val; else in0 = chg_val;
        end
      end
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      mag = model_mag(v);
      check({tag, "_latency"}, cyc, W + 1);
      check({tag, "_busy_cycles"}, bcyc, W + 1);
      check({tag, "_ack0"}, 32'(ack0), 32'(!id));
      check({tag, "_ack1"}, 32'(ack1), 32'(id));
      check({tag, "_owner"}, 32'(owner), 32'(id));
      check({tag, "_centena"}, 32'(centena), mag / 100);
      check({tag, "_dezena"}, 32'(dezena), (mag / 10) % 10);
      check({tag, "_unidade"}, 32'(unidade), mag % 10);
      check({tag, "_negative"}, 32'(negative), 32'(model_neg(v)));
    end
    if (id) req1 = 1'b0; else req0 = 1'b0;
    last_m = id;
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'({valid, ack0, ack1}), 32'd0);
  endtask

  task automatic single(input string tag, input bit id, input logic [W-1:0] v,
                        input int drop_at, input int chg_at, input logic [W-1:0] chg_val);
    if (id) begin req1 = 1'b1; in1 = v; end
    else    begin req0 = 1'b1; in0 = v; end
    expect_result(tag, id, v, drop_at, chg_at, chg_val);
  endtask

  task automatic tie(input string tag, input logic [W-1:0] a0, input logic [W-1:0] a1);
    bit first;
    req0  = 1'b1;
    req1  = 1'b1;
    in0   = a0;
    in1   = a1;
    first = ~last_m;
    expect_result({tag, "_first"}, first, first ? a1 : a0, 0, 0, '0);
    expect_result({tag, "_second"}, ~first, first ? a0 : a1, 0, 0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vcnt;
    do_reset();

    // Reset state.
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_valid", 32'({valid, ack0, ack1}), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_digits", 32'({centena, dezena, unidade}), 32'd0);
    check("rst_negative", 32'(negative), 32'd0);

    // Directed scenarios.
    single("max255", 1'b0, 8'd255, 0, 0, '0);
    single("r1_ff",  1'b1, 8'hFF, 0, 0, '0);
    single("r1_80",  1'b1, 8'h80, 0, 0, '0);
    single("r1_127", 1'b1, 8'd127, 0, 0, '0);
    tie("tie_a", 8'd42, 8'd99);
    tie("tie_b", 8'd42, 8'd99);
    single("opchange", 1'b0, 8'd10, 0, 3, 8'd200);
    single("drop1", 1'b1, 8'd63, 4, 0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("drop1_no_grant", 32'(busy), 32'd0);
    end

    // Reset during the 4th SHIFT cycle abandons the conversion.
    req0 = 1'b1;
    in0  = 8'd77;
    repeat (4) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    req0  = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    last_m = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_digits", 32'({centena, dezena, unidade}), 32'd0);
    check("midrst_flags", 32'({owner, negative}), 32'd0);
    vcnt = 0;
    repeat (2*W) begin
      @(negedge clk);
      if (valid || ack0 || ack1) vcnt++;
    end
    check("midrst_no_ack", vcnt, 0);
    single("after_rst_zero", 1'b0, 8'd0, 0, 0, '0);
    tie("tie_after_rst", 8'd5, 8'd250);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      int mode = int'($urandom_range(0, 2));
      logic [W-1:0] a0 = W'($urandom);
      logic [W-1:0] a1 = W'($urandom);
      int drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, W)) : 0;
      int chg  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, W)) : 0;
      logic [W-1:0] cv = W'($urandom);
      case (mode)
        0:       single("rand_r0", 1'b0, a0, drop, chg, cv);
        1:       single("rand_r1", 1'b1, a1, drop, chg, cv);
        default: tie("rand_tie", a0, a1);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
